leds_seq_ctrl: RTL and testbench

//  Sequencer that drives the 5 board LEDs (LED0..LED4) with selectable patterns.

---
 rtl/leds_seq_ctrl_if.sv | 17 +
 rtl/leds_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_leds_seq_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/leds_seq_ctrl_if.sv
// Control interface for leds_seq_ctrl.
//   start : 1-cycle pulse, (re)starts the sequence with mode
//   stop  : 1-cycle pulse, returns to IDLE (wins over start)
//   hold  : level, freezes prescaler and pattern while in RUN
//   mode  : pattern select, sampled on an accepted start
//   busy  : 1 while the sequencer is in RUN
// master = controller side (drives commands), slave = sequencer side.
interface leds_seq_ctrl_if;
  logic       start;
  logic       stop;
  logic       hold;
  logic [1:0] mode;
  logic       busy;

  modport master (output start, output stop, output hold, output mode, input busy);
  modport slave  (input start, input stop, input hold, input mode, output busy);
endinterface

// File: rtl/leds_seq_ctrl.sv
// LED pattern sequencer for the 5 board LEDs.
// A prescaler of DIV cycles paces pattern steps; four patterns selected by mode:
//   0 steady 11111, 1 rotate, 2 bounce, 3 blink.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   bus (slave)    : start/stop/hold/mode commands, busy status
//   LED0..LED4     : LED drive, LED0 = pattern bit 0
//   duty           : global brightness (only with LED_PWM_EN)
// Optional feature: define LED_PWM_EN to add PWM brightness control.
module leds_seq_ctrl #(
  parameter int unsigned DIV      = 12000000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  leds_seq_ctrl_if.slave      bus,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] duty,
`endif
  output logic                LED0,
  output logic                LED1,
  output logic                LED2,
  output logic                LED3,
  output logic                LED4
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned LW = 5;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [LW-1:0]   pattern;
  logic [CW-1:0]   presc;
  logic            dir_down;
  logic [1:0]      mode_q;
  logic            busy_q;

  logic [LW-1:0]   init_pat_c;
  logic [LW-1:0]   step_pat_c;
  logic            step_dir_c;
  logic            tick_c;

  // Prescaler terminal count; hold suppresses the tick
  assign tick_c = (presc == CW'(DIV - 1)) && !bus.hold;

  // Initial pattern loaded on an accepted start
  always_comb begin
    init_pat_c = 5'b11111;
    case (bus.mode)
      2'd1, 2'd2: init_pat_c = 5'b00001;
      default:    init_pat_c = 5'b11111;
    endcase
  end

  // Next pattern/direction for one step of the latched mode
  always_comb begin
    step_pat_c = pattern;
    step_dir_c = dir_down;
    case (mode_q)
      2'd1: step_pat_c = {pattern[3:0], pattern[4]};
      2'd2: begin
        if (!dir_down) begin
          step_pat_c = {pattern[3:0], 1'b0};
          if (step_pat_c == 5'b10000) step_dir_c = 1'b1;
        end else begin
          step_pat_c = {1'b0, pattern[4:1]};
          if (step_pat_c == 5'b00001) step_dir_c = 1'b0;
        end
      end
      2'd3:    step_pat_c = ~pattern;
      default: step_pat_c = pattern;
    endcase
  end

  // Sequencer state, prescaler and pattern
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pattern  <= '0;
      presc    <= '0;
      dir_down <= 1'b0;
      mode_q   <= 2'd0;
      busy_q   <= 1'b0;
    end else if (bus.stop) begin
      state   <= IDLE;
      pattern <= '0;
      presc   <= '0;
      busy_q  <= 1'b0;
    end else if (bus.start) begin
      state    <= RUN;
      busy_q   <= 1'b1;
      mode_q   <= bus.mode;
      presc    <= '0;
      dir_down <= 1'b0;
      pattern  <= init_pat_c;
    end else if (state == RUN && !bus.hold) begin
      if (tick_c) begin
        presc    <= '0;
        pattern  <= step_pat_c;
        dir_down <= step_dir_c;
      end else begin
        presc <= presc + CW'(1);
      end
    end
  end

  assign bus.busy = busy_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pc;
  logic                pwm_on_c;

  // Free-running PWM counter, runs in every state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= '0;
    else       pc <= pc + PWM_BITS'(1);
  end

  assign pwm_on_c = (pc < duty);
  assign {LED4, LED3, LED2, LED1, LED0} = pattern & {LW{pwm_on_c}};
`else
  assign {LED4, LED3, LED2, LED1, LED0} = pattern;
`endif

endmodule

// File: tb/tb_leds_seq_ctrl.sv
// Directed self-checking bench for leds_seq_ctrl with DIV=4.
module tb_leds_seq_ctrl;
  localparam int unsigned DIV = 4;

  logic clk;
  logic rstn;
  logic led0, led1, led2, led3, led4;
  logic [4:0] leds;
`ifdef LED_PWM_EN
  logic [3:0] duty;
`endif

  int n_cmp;
  int n_err;

  leds_seq_ctrl_if bus ();

  leds_seq_ctrl #(.DIV(DIV), .PWM_BITS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
`ifdef LED_PWM_EN
    .duty (duty),
`endif
    .LED0 (led0),
    .LED1 (led1),
    .LED2 (led2),
    .LED3 (led3),
    .LED4 (led4)
  );

  assign leds = {led4, led3, led2, led1, led0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m);
    bus.mode  = m;
    bus.start = 1'b1;
    clks(1);
    bus.start = 1'b0;
  endtask

  logic [4:0] bounce [10];
  int         cnt [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    bounce = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
               5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    bus.mode  = 2'd0;
`ifdef LED_PWM_EN
    duty = 4'd15;
`endif
    clks(2);
    check("reset_leds", 8'(leds), 8'h00);
    check("reset_busy", 8'(bus.busy), 8'h00);
    rstn = 1'b1;
    clks(2);
    check("idle_leds", 8'(leds), 8'h00);

`ifndef LED_PWM_EN
    // Rotate; mode change mid-run must be ignored
    do_start(2'd1);
    check("rot_first", 8'(leds), 8'b00001);
    check("rot_busy", 8'(bus.busy), 8'h01);
    bus.mode = 2'd3;
    clks(3);
    check("rot_pre_tick", 8'(leds), 8'b00001);
    clks(1);
    check("rot_s1", 8'(leds), 8'b00010);
    clks(4);
    check("rot_s2", 8'(leds), 8'b00100);
    clks(4);
    check("rot_s3", 8'(leds), 8'b01000);
    clks(4);
    check("rot_s4", 8'(leds), 8'b10000);
    clks(4);
    check("rot_wrap", 8'(leds), 8'b00001);

    // Async reset mid-run takes effect before the next clock
    clks(2);
    rstn = 1'b0;
    #1;
    check("rst_mid_leds", 8'(leds), 8'h00);
    check("rst_mid_busy", 8'(bus.busy), 8'h00);
    clks(1);
    rstn = 1'b1;
    clks(1);

    // Bounce
    do_start(2'd2);
    check("bnc_0", 8'(leds), 8'(bounce[0]));
    for (int i = 1; i < 10; i++) begin
      clks(4);
      check($sformatf("bnc_%0d", i), 8'(leds), 8'(bounce[i]));
    end

    // Blink with hold
    do_start(2'd3);
    check("blk_init", 8'(leds), 8'b11111);
    clks(4);
    check("blk_tick1", 8'(leds), 8'b00000);
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clks(1);
      check($sformatf("hold_%0d", i), 8'(leds), 8'b00000);
    end
    bus.hold = 1'b0;
    clks(3);
    check("hold_rel3", 8'(leds), 8'b00000);
    clks(1);
    check("hold_rel4", 8'(leds), 8'b11111);

    // Simultaneous start and stop: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    clks(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_leds", 8'(leds), 8'h00);
    check("ss_busy", 8'(bus.busy), 8'h00);
    clks(6);
    check("ss_idle", 8'(leds), 8'h00);

    // Steady mode, restart from RUN
    do_start(2'd1);
    clks(4);
    check("pre_restart", 8'(leds), 8'b00010);
    do_start(2'd0);
    check("steady_0", 8'(leds), 8'b11111);
    for (int i = 1; i <= 3; i++) begin
      clks(4);
      check($sformatf("steady_%0d", i), 8'(leds), 8'b11111);
    end
    check("steady_busy", 8'(bus.busy), 8'h01);

    // Plain stop
    bus.stop = 1'b1;
    clks(1);
    bus.stop = 1'b0;
    check("stop_leds", 8'(leds), 8'h00);
    check("stop_busy", 8'(bus.busy), 8'h00);
`else
    // Brightness: steady mode, count high cycles over one PWM period
    do_start(2'd0);
    check("pwm_busy", 8'(bus.busy), 8'h01);
    duty = 4'd4;
    clks(16);
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 5; k++) if (leds[k]) cnt[k]++;
      clks(1);
    end
    for (int k = 0; k < 5; k++) check($sformatf("pwm4_led%0d", k), 8'(cnt[k]), 8'd4);
    duty = 4'd0;
    #1;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 5; k++) if (leds[k]) cnt[k]++;
      clks(1);
    end
    for (int k = 0; k < 5; k++) check($sformatf("pwm0_led%0d", k), 8'(cnt[k]), 8'd0);
    duty = 4'd15;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 5; k++) if (leds[k]) cnt[k]++;
      clks(1);
    end
    for (int k = 0; k < 5; k++) check($sformatf("pwm15_led%0d", k), 8'(cnt[k]), 8'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
